// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture state encoding and default servo timing
// constants in 100 MHz board-clock cycles.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    HIGH,
    LOW
  } pwm_cap_state_t;

  localparam int unsigned PWM_TIMEOUT   = 4_000_000;  // 40 ms
  localparam int unsigned PWM_MIN_PULSE = 50_000;     // 0.5 ms
  localparam int unsigned PWM_MAX_PULSE = 250_000;    // 2.5 ms

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus one delay flop, producing the synchronized level
// and single-cycle rise/fall pulses for an asynchronous input.
module sync_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_s,
  output logic o_rise,
  output logic o_fall,
  output logic o_primed
);

  logic       r_s1;
  logic       r_s2;
  logic       r_s_d;
  logic [1:0] r_fill;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s_d  <= 1'b0;
      r_fill <= 2'b00;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_s_d  <= r_s2;
      r_fill <= {r_fill[0], 1'b1};
    end
  end

  assign o_s    = r_s2;
  assign o_rise = r_s2 & ~r_s_d;
  assign o_fall = ~r_s2 & r_s_d;
  // o_s carries a real sample (not a reset zero) once two clocks have passed.
  assign o_primed = r_fill[1];

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rising-to-rising period of an asynchronous PWM input
// in clock cycles, with range and signal-loss flags.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = PWM_TIMEOUT,
  parameter int unsigned MIN_PULSE      = PWM_MIN_PULSE,
  parameter int unsigned MAX_PULSE      = PWM_MAX_PULSE
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_pwm_in,
  output logic [CNT_WIDTH-1:0] o_pulse_width,
  output logic [CNT_WIDTH-1:0] o_period,
  output logic                 o_width_valid,
  output logic                 o_period_valid,
  output logic                 o_out_of_range,
  output logic                 o_signal_lost
);

  localparam logic [CNT_WIDTH-1:0] LP_TIMEOUT = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] LP_MIN     = CNT_WIDTH'(MIN_PULSE);
  localparam logic [CNT_WIDTH-1:0] LP_MAX     = CNT_WIDTH'(MAX_PULSE);
  localparam logic [CNT_WIDTH-1:0] LP_ONE     = CNT_WIDTH'(1);

  logic                 w_s;
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_primed;
  logic [CNT_WIDTH-1:0] w_hi_inc;
  logic [CNT_WIDTH-1:0] w_per_inc;
  logic                 w_oor;
  logic                 w_timeout;

  pwm_cap_state_t       r_state;
  logic [CNT_WIDTH-1:0] r_hi_cnt;
  logic [CNT_WIDTH-1:0] r_per_cnt;
  logic [CNT_WIDTH-1:0] r_pulse_width;
  logic [CNT_WIDTH-1:0] r_period;
  logic                 r_width_valid;
  logic                 r_period_valid;
  logic                 r_out_of_range;
  logic                 r_signal_lost;

  sync_edge_detect u_sync (
    .i_clk    (i_clock),
    .i_rst    (i_reset),
    .i_async  (i_pwm_in),
    .o_s      (w_s),
    .o_rise   (w_rise),
    .o_fall   (w_fall),
    .o_primed (w_primed)
  );

  // Counters stop at the timeout value instead of wrapping.
  assign w_hi_inc  = (r_hi_cnt == LP_TIMEOUT) ? r_hi_cnt : r_hi_cnt + LP_ONE;
  assign w_per_inc = (r_per_cnt == LP_TIMEOUT) ? r_per_cnt : r_per_cnt + LP_ONE;
  assign w_oor     = (r_hi_cnt < LP_MIN) || (r_hi_cnt > LP_MAX);
  assign w_timeout = (r_per_cnt == LP_TIMEOUT);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_hi_cnt       <= '0;
      r_per_cnt      <= '0;
      r_pulse_width  <= '0;
      r_period       <= '0;
      r_width_valid  <= 1'b0;
      r_period_valid <= 1'b0;
      r_out_of_range <= 1'b0;
      r_signal_lost  <= 1'b1;
    end else begin
      r_width_valid  <= 1'b0;
      r_period_valid <= 1'b0;
      // A timeout takes priority over any edge seen on the same cycle.
      if ((r_state == HIGH || r_state == LOW) && w_timeout) begin
        r_signal_lost  <= 1'b1;
        r_pulse_width  <= '0;
        r_period       <= '0;
        r_out_of_range <= 1'b0;
        r_hi_cnt       <= '0;
        r_per_cnt      <= '0;
        r_state        <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_primed && !w_s) r_state <= ARMED;
          end
          ARMED: begin
            if (w_rise) begin
              r_hi_cnt  <= LP_ONE;
              r_per_cnt <= LP_ONE;
              r_state   <= HIGH;
            end
          end
          HIGH: begin
            r_hi_cnt  <= w_hi_inc;
            r_per_cnt <= w_per_inc;
            if (w_fall) begin
              r_pulse_width  <= r_hi_cnt;
              r_width_valid  <= 1'b1;
              r_out_of_range <= w_oor;
              r_signal_lost  <= 1'b0;
              r_state        <= LOW;
            end
          end
          LOW: begin
            if (w_rise) begin
              r_period       <= r_per_cnt;
              r_period_valid <= 1'b1;
              r_hi_cnt       <= LP_ONE;
              r_per_cnt      <= LP_ONE;
              r_state        <= HIGH;
            end else begin
              r_per_cnt <= w_per_inc;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_pulse_width  = r_pulse_width;
  assign o_period       = r_period;
  assign o_width_valid  = r_width_valid;
  assign o_period_valid = r_period_valid;
  assign o_out_of_range = r_out_of_range;
  assign o_signal_lost  = r_signal_lost;

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM signal, such as a servo feedback line or an RC receiver channel, in clock cycles. It is the receive-side counterpart of the servo PWM generators. It reports high-time (pulse width) and rising-to-rising period as 32-bit values, in the same units the regfile uses for `pulse_width_*`, so processor code can read back or mirror them. It runs on the fast board clock (100 MHz), not the divided CPU clock, and adds range and signal-loss flags.

## Interface
- `CNT_WIDTH`, 32: width of the counters and outputs.
- `TIMEOUT_CYCLES`, 4_000_000: cycles without an edge before the signal counts as lost (40 ms).
- `MIN_PULSE`, 50_000: smallest in-range pulse width (0.5 ms).
- `MAX_PULSE`, 250_000: largest in-range pulse width (2.5 ms).
- `clock`  in  1  board clock, 100 MHz.
- `reset`  in  1  asynchronous, active-high; one clock domain.
- `pwm_in`  in  1  asynchronous PWM input.
- `pulse_width`  out  CNT_WIDTH  last measured high-time in cycles.
- `period`  out  CNT_WIDTH  last measured rising-to-rising period in cycles.
- `width_valid`  out  1  one-cycle strobe when `pulse_width` updates.
- `period_valid`  out  1  one-cycle strobe when `period` updates.
- `out_of_range`  out  1  last width was `< MIN_PULSE` or `> MAX_PULSE`; held until the next width update.
- `signal_lost`  out  1  no valid pulse since reset or since the last timeout.

## Operation
- `pwm_in` passes through a 2-flop synchronizer, giving `s`. A third flop holds `s_d`.
  - `rise = s & ~s_d`
  - `fall = ~s & s_d`
- State machine states: IDLE, ARMED, HIGH, LOW. Reset enters IDLE.
  - IDLE: wait for `s==0`, then go to ARMED. This discards a pulse already in progress at reset.
  - ARMED: on `rise`, set `hi_cnt<=1` and `per_cnt<=1`, go to HIGH. No `period_valid` on this first rise.
  - HIGH: `hi_cnt` and `per_cnt` each increment by 1 per cycle. On `fall`:
    - `pulse_width<=hi_cnt`, `width_valid<=1`
    - `out_of_range<=` range check on `hi_cnt`
    - `signal_lost<=0`
    - `per_cnt` increments, go to LOW.
  - LOW: `per_cnt` increments. On `rise`: `period<=per_cnt`, `period_valid<=1`, `hi_cnt<=1`, `per_cnt<=1`, go to HIGH.
- Result: a high time of N sampled cycles gives `pulse_width==N`, and a period of P cycles gives `period==P`. Synchronizer delay cancels because both edges see the same delay.
- Counters saturate at `TIMEOUT_CYCLES` and never wrap.
- Timeout: in HIGH or LOW, when `per_cnt` reaches `TIMEOUT_CYCLES`:
  - `signal_lost<=1`; `pulse_width`, `period` and `out_of_range` clear to 0.
  - Go to IDLE. No strobe on the timeout cycle.
- ARMED has no timeout. `signal_lost` stays at its current value.
- Range check is inclusive: `MIN_PULSE<=w<=MAX_PULSE` gives `out_of_range=0`.
- Glitches: a 1-cycle high pulse is measured as width 1 and flagged out-of-range. No filtering.

## Timing
- Reset values: `pulse_width=0`, `period=0`, `width_valid=0`, `period_valid=0`, `out_of_range=0`, `signal_lost=1`. All counters and synchronizer flops are 0, state is IDLE.
- Latency: the `width_valid` strobe is asserted 3 clocks after the first `clock` edge that samples `pwm_in` low (2 synchronizer stages plus 1 registered output). `period_valid` has the same latency from the sampled rising edge.
- All outputs are registered. Strobes last exactly 1 cycle, and each output value is stable from its strobe until the next update.
- Simultaneous timeout and edge on the same cycle: the timeout wins and the edge is ignored.
- Reset asserted mid-pulse returns everything to reset values immediately (asynchronously). After release, the block waits for low, then a rise.
- Minimum measurable high or low phase is 1 cycle.

## Structure
- Shared package `pwm_pkg`:
  - state enum `pwm_cap_state_t` {IDLE, ARMED, HIGH, LOW}
  - default constants `PWM_TIMEOUT`, `PWM_MIN_PULSE`, `PWM_MAX_PULSE`, also used by the servo generators
- Sub-module `sync_edge_detect`: 2-flop synchronizer plus delay flop. Outputs `s`, `rise`, `fall`. Reusable for the button inputs.
- The top level holds the state machine, the two counters, the output registers and the range compare.

## Test plan
- Steady 1.5 ms / 20 ms: `pwm_in` high 150_000 cycles, low 1_850_000, repeated 3 periods.
  - `width_valid` with `pulse_width=150_000` each period.
  - `period_valid` with `period=2_000_000` from the 2nd rise on.
  - `out_of_range=0`, `signal_lost` falls at the first width strobe.
- Range limits: widths 49_999, 50_000, 250_000, 250_001 → `out_of_range` = 1, 0, 0, 1.
- Start mid-pulse: `pwm_in=1` at reset release for 100 cycles, then low 1_000 cycles, then high 200 cycles.
  - No strobe for the first pulse.
  - `pulse_width=200`.
  - No `period_valid` until the next rise.
- Signal loss: after a valid period, hold `pwm_in` low.
  - `signal_lost` goes to 1 exactly when `per_cnt` reaches 4_000_000; `pulse_width`, `period` and `out_of_range` read 0.
  - A new pulse of 100_000 cycles clears `signal_lost` and reports 100_000.
- Glitch: a 1-cycle high blip → `pulse_width=1`, `out_of_range=1`.
- Async reset mid-measurement: assert `reset` 10 cycles into a 150_000-cycle pulse.
  - Outputs return to reset values within the same cycle.
  - After release, the first valid report comes from the following full pulse.
